test_port_snooper: RTL



---
 rtl/test_port_snooper_if.sv | 32 +++
 rtl/test_port_snooper.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/test_port_snooper_if.sv
// Snoop-side bus bundle for test_port_snooper.
// Groups the data-memory write bus and the result stream toward the checker.
// Optional macro SNOOP_TIMESTAMP_EN adds the out_cycle field to the stream.
interface test_port_snooper_if;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
`ifdef SNOOP_TIMESTAMP_EN
  logic [15:0] out_cycle;
`endif

  // Driver of the memory bus and consumer of the result stream.
  modport master (
    output mem_addr, mem_wdata, mem_wen, out_ready,
    input  out_valid, out_data
`ifdef SNOOP_TIMESTAMP_EN
    , input out_cycle
`endif
  );

  // Snooper view: observes the bus and produces the result stream.
  modport slave (
    input  mem_addr, mem_wdata, mem_wen, out_ready,
    output out_valid, out_data
`ifdef SNOOP_TIMESTAMP_EN
    , output out_cycle
`endif
  );
endinterface

// File: rtl/test_port_snooper.sv
// test_port_snooper: watches data-memory stores to the test port word address,
// byte-swaps them into readable order, collapses stall-extended writes into one
// event, and queues results between the begin and end markers in a small FIFO.
// Optional macro SNOOP_TIMESTAMP_EN: stores a free-running 16-bit cycle stamp
// with every entry and presents it on out_cycle alongside out_data.
module test_port_snooper #(
  parameter logic [29:0] TEST_PORT = 30'h10,
  parameter logic [31:0] BEGIN_SYM = 32'h00000168,
  parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3
) (
  input  logic                clk,
  input  logic                rst,
  test_port_snooper_if.slave  bus,
  output logic [AW:0]         fifo_count,
  output logic                armed,
  output logic                done,
  output logic                overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Stores arrive little-endian; the checker compares in readable order.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t      state_r;
  logic        armed_r;
  logic        done_r;
  logic        overflow_r;
  logic        wen_hold_r;
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [31:0] mem_r [DEPTH];

  logic [31:0] swapped_s;
  logic        event_s;
  logic [AW:0] count_s;
  logic        full_s;
  logic        empty_s;
  logic        pop_s;
  logic        push_req_s;
  logic        push_ok_s;
  logic        drop_s;

  assign swapped_s  = byte_swap(bus.mem_wdata);
  // Only the rising edge of wen counts, so a stall-held store is one event.
  assign event_s    = bus.mem_wen && !wen_hold_r && (bus.mem_addr == TEST_PORT);
  assign count_s    = wr_ptr_r - rd_ptr_r;
  assign full_s     = (count_s == DEPTH_C);
  assign empty_s    = (count_s == {(AW+1){1'b0}});
  assign pop_s      = !empty_s && bus.out_ready;
  assign push_req_s = event_s && (state_r == ARMED);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign drop_s     = push_req_s && full_s && !pop_s;

  assign bus.out_valid = !empty_s;
  assign bus.out_data  = mem_r[rd_ptr_r[AW-1:0]];
  assign fifo_count    = count_s;
  assign armed         = armed_r;
  assign done          = done_r;
  assign overflow      = overflow_r;

  // Remember last cycle's write enable regardless of address for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_hold_r <= 1'b0;
    end else begin
      wen_hold_r <= bus.mem_wen;
    end
  end

  // Capture FSM: begin marker arms, end marker (still queued) finishes for good.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      armed_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (event_s && (swapped_s == BEGIN_SYM)) begin
            state_r <= ARMED;
            armed_r <= 1'b1;
          end
        end
        ARMED: begin
          if (event_s && (swapped_s == END_SYM)) begin
            state_r <= DONE;
            armed_r <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
          armed_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for a push lost to a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FIFO storage, cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= swapped_s;
    end
  end

`ifdef SNOOP_TIMESTAMP_EN
  logic [15:0] cycle_r;
  logic [15:0] ts_r [DEPTH];

  assign bus.out_cycle = ts_r[rd_ptr_r[AW-1:0]];

  // Free-running cycle counter, wraps naturally at 16'hFFFF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_r <= 16'h0000;
    end else begin
      cycle_r <= cycle_r + 16'h0001;
    end
  end

  // Stamp each accepted entry with the cycle of its push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ts_r[i] <= 16'h0000;
      end
    end else if (push_ok_s) begin
      ts_r[wr_ptr_r[AW-1:0]] <= cycle_r;
    end
  end
`endif

endmodule
